// File: rtl/serial_parity_checker.sv
// Serial receiver: assembles DATA_BITS bits LSB-first, folds them into an XOR
// accumulator, then checks one trailing parity bit against the accumulator.
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_calc,
  output logic                 parity_err
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic fold_bit(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [CW-1:0]        count_r;
  logic                 acc_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 clear_s;
  logic                 take_data_s;
  logic                 take_par_s;
  logic                 busy_r;
  logic                 done_r;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 parity_calc_r;
  logic                 parity_err_r;

  // Next-state decode; start is only honoured in IDLE and DONE
  always_comb begin
    state_s     = state_r;
    clear_s     = 1'b0;
    take_data_s = 1'b0;
    take_par_s  = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_DATA;
          clear_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DATA: begin
        if (bit_valid) begin
          take_data_s = 1'b1;
          if (count_r == LAST_IDX) begin
            state_s = S_PARITY;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_valid) begin
          take_par_s = 1'b1;
          state_s    = S_DONE;
        end else begin
          state_s = S_PARITY;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Drop the incoming bit into the slot addressed by the bit counter
  always_comb begin
    shift_s = shift_r;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (count_r == CW'(i)) begin
        shift_s[i] = bit_in;
      end else begin
        shift_s[i] = shift_r[i];
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      count_r       <= '0;
      acc_r         <= 1'b0;
      shift_r       <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      data_out_r    <= '0;
      parity_calc_r <= 1'b0;
      parity_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_DATA) || (state_s == S_PARITY);
      done_r  <= (state_s == S_DONE);
      if (clear_s) begin
        count_r <= '0;
        acc_r   <= 1'b0;
        shift_r <= '0;
      end else if (take_data_s) begin
        count_r <= count_r + CW'(1);
        acc_r   <= fold_bit(acc_r, bit_in);
        shift_r <= shift_s;
      end else begin
        count_r <= count_r;
        acc_r   <= acc_r;
        shift_r <= shift_r;
      end
      // Results only move on the edge that enters DONE
      if (take_par_s) begin
        data_out_r    <= shift_r;
        parity_calc_r <= fold_bit(acc_r, ODD_PARITY);
        parity_err_r  <= fold_bit(fold_bit(acc_r, bit_in), ODD_PARITY);
      end else begin
        data_out_r    <= data_out_r;
        parity_calc_r <= parity_calc_r;
        parity_err_r  <= parity_err_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign data_out    = data_out_r;
  assign parity_calc = parity_calc_r;
  assign parity_err  = parity_err_r;

endmodule
